// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding uart_top's dintx/send handshake.
// Bytes are queued from the system side and presented one at a time. The next
// byte waits for donetx and then for one extra GAP cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   dintx,
  output logic                    send,
  input  logic                    donetx
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic                  full_q,     full_d;
  logic                  empty_q,    empty_d;
  logic                  overflow_q, overflow_d;
  state_e                state_q,    state_d;
  logic                  send_q,     send_d;
  logic                  busy_q,     busy_d;
  logic [DATA_WIDTH-1:0] dintx_q,    dintx_d;

  logic                  wr_accept;
  logic                  pop;

  // Next-state logic for pointers, occupancy flags and the transmit FSM.
  // full/empty come from the registered count, so a write that arrives while
  // full is dropped even when a pop happens on the same edge.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    dintx_d    = dintx_q;
    pop        = 1'b0;
    wr_accept  = wr_en && !full_q;
    overflow_d = wr_en && full_q;

    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          dintx_d = mem_q[rd_ptr_q];
          state_d = SEND;
        end
      end
      SEND: begin
        if (donetx) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(wr_accept) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    send_d  = (state_d == SEND);
    busy_d  = (state_d != IDLE);
  end

  // Storage array; needs no reset because the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Control, status and FSM registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      dintx_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      send_q     <= send_d;
      busy_q     <= busy_d;
      dintx_q    <= dintx_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign dintx    = dintx_q;
  assign send     = send_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: DEPTH=16 and DEPTH=4 instances. A scoreboard queue
// holds bytes that are expected on dintx. Each rising edge of send pops one
// byte and compares it against dintx.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       donetx = 1'b0;
  logic       sel = 1'b0;       // 0: DEPTH=16 instance, 1: DEPTH=4 instance
  bit         auto_done = 1'b0;

  logic       full16, empty16, overflow16, busy16, send16;
  logic [4:0] count16;
  logic [7:0] dintx16;
  logic       full4, empty4, overflow4, busy4, send4;
  logic [2:0] count4;
  logic [7:0] dintx4;

  logic       o_full, o_empty, o_overflow, o_busy, o_send;
  logic [4:0] o_count;
  logic [7:0] o_dintx;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en && !sel),
    .full(full16), .empty(empty16), .count(count16), .overflow(overflow16),
    .busy(busy16), .dintx(dintx16), .send(send16), .donetx(donetx && !sel)
  );

  uart_tx_fifo #(.DEPTH(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en && sel),
    .full(full4), .empty(empty4), .count(count4), .overflow(overflow4),
    .busy(busy4), .dintx(dintx4), .send(send4), .donetx(donetx && sel)
  );

  assign o_full     = sel ? full4     : full16;
  assign o_empty    = sel ? empty4    : empty16;
  assign o_overflow = sel ? overflow4 : overflow16;
  assign o_busy     = sel ? busy4     : busy16;
  assign o_send     = sel ? send4     : send16;
  assign o_dintx    = sel ? dintx4    : dintx16;
  assign o_count    = sel ? {2'b00, count4} : count16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit push);
    wr_data = b;
    wr_en   = 1'b1;
    if (push) sb.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  // Write only once the selected FIFO has room, so no byte is dropped.
  task automatic wr_safe(input logic [7:0] b);
    int unsigned n = 0;
    while (o_full && n < 50) begin
      step();
      n++;
    end
    chk("wr_wait_timeout", {31'd0, o_full}, 32'd0);
    wr(b, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(o_empty && !o_busy) && n < budget) begin
      step();
      n++;
    end
    chk(tag, {30'd0, o_empty, o_busy}, 32'd2);
  endtask

  // Scoreboard monitor: compare each newly presented byte, check send-low gap.
  logic        prev_send = 1'b0;
  bit          seen = 1'b0;
  int unsigned gap = 0;
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst) begin
      prev_send = 1'b0;
      seen      = 1'b0;
      gap       = 0;
    end else begin
      if (o_send && !prev_send) begin
        exp_b = 8'hxx;
        if (sb.size() > 0) exp_b = sb.pop_front();
        chk("tx_byte", {24'd0, o_dintx}, {24'd0, exp_b});
        if (seen) chk("send_gap_min", {31'd0, gap >= 2}, 32'd1);
        seen = 1'b1;
        gap  = 0;
      end else if (!o_send) begin
        gap++;
      end
      prev_send = o_send;
    end
  end

  // uart_top stand-in: completes each frame after send has been high 3 cycles.
  initial begin
    int unsigned hi = 0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_done) begin
        if (o_send && !donetx) begin
          hi++;
          if (hi >= 3) begin
            donetx = 1'b1;
            hi = 0;
          end
        end else begin
          donetx = 1'b0;
        end
      end else begin
        hi = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned rises;
    int unsigned low;
    logic        prev;

    // Reset then idle
    rst = 1'b1;
    step();
    step();
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_count", {27'd0, o_count}, 32'd0);
    chk("rst_send", {31'd0, o_send}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_dintx", {24'd0, o_dintx}, 32'h00);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_send", {31'd0, o_send}, 32'd0);
    chk("idle_count", {27'd0, o_count}, 32'd0);

    // Single byte
    wr(8'hAA, 1'b1);
    chk("single_count_k", {27'd0, o_count}, 32'd1);
    chk("single_send_k", {31'd0, o_send}, 32'd0);
    step();
    chk("single_send_k1", {31'd0, o_send}, 32'd1);
    chk("single_dintx", {24'd0, o_dintx}, 32'hAA);
    chk("single_count_k1", {27'd0, o_count}, 32'd0);
    chk("single_busy_k1", {31'd0, o_busy}, 32'd1);
    donetx = 1'b1;
    step();
    donetx = 1'b0;
    chk("single_send_gap", {31'd0, o_send}, 32'd0);
    chk("single_busy_gap", {31'd0, o_busy}, 32'd1);
    step();
    chk("single_busy_idle", {31'd0, o_busy}, 32'd0);
    chk("single_dintx_hold", {24'd0, o_dintx}, 32'hAA);

    // Burst of three on consecutive edges
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    chk("burst_count_peak", {27'd0, o_count}, 32'd2);
    chk("burst_first_dintx", {24'd0, o_dintx}, 32'h11);
    auto_done = 1'b1;
    rises = 0;
    low   = 0;
    prev  = o_send;
    for (int i = 0; i < 100 && rises < 2; i++) begin
      step();
      if (o_send && !prev) begin
        chk("burst_gap_exact", low, 32'd2);
        rises++;
        low = 0;
      end else if (!o_send) begin
        low++;
      end
      prev = o_send;
    end
    chk("burst_rises", rises, 32'd2);
    wait_idle("burst_drain", 100);

    // Fill and overflow with the line stalled
    auto_done = 1'b0;
    for (int i = 0; i < 17; i++) wr(8'(i), 1'b1);
    chk("fill_count", {27'd0, o_count}, 32'd16);
    chk("fill_full", {31'd0, o_full}, 32'd1);
    chk("fill_overflow_quiet", {31'd0, o_overflow}, 32'd0);
    wr(8'h11, 1'b0);
    chk("ovf_pulse", {31'd0, o_overflow}, 32'd1);
    chk("ovf_count", {27'd0, o_count}, 32'd16);
    step();
    chk("ovf_pulse_end", {31'd0, o_overflow}, 32'd0);
    chk("ovf_count_hold", {27'd0, o_count}, 32'd16);
    auto_done = 1'b1;
    wait_idle("fill_drain", 400);
    chk("fill_sb_empty", sb.size(), 32'd0);

    // Wrap-around on the DEPTH=4 instance
    sel = 1'b1;
    step();
    for (int i = 0; i < 3; i++) wr_safe(8'h50 + 8'(i));
    step();
    step();
    for (int i = 3; i < 7; i++) wr_safe(8'h50 + 8'(i));
    for (int i = 7; i < 10; i++) wr_safe(8'h50 + 8'(i));
    wait_idle("wrap_drain", 400);
    chk("wrap_empty", {31'd0, o_empty}, 32'd1);
    chk("wrap_sb_empty", sb.size(), 32'd0);
    chk("wrap_last_dintx", {24'd0, o_dintx}, 32'h59);

    // Reset mid-transmission
    sel = 1'b0;
    auto_done = 1'b0;
    step();
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i), 1'b1);
    chk("midrst_count_pre", {27'd0, o_count}, 32'd3);
    chk("midrst_send_pre", {31'd0, o_send}, 32'd1);
    chk("midrst_dintx_pre", {24'd0, o_dintx}, 32'hA0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("midrst_send", {31'd0, o_send}, 32'd0);
    chk("midrst_count", {27'd0, o_count}, 32'd0);
    chk("midrst_empty", {31'd0, o_empty}, 32'd1);
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_dintx", {24'd0, o_dintx}, 32'h00);
    donetx = 1'b1;
    step();
    donetx = 1'b0;
    repeat (5) step();
    chk("stray_send", {31'd0, o_send}, 32'd0);
    chk("stray_busy", {31'd0, o_busy}, 32'd0);
    chk("stray_count", {27'd0, o_count}, 32'd0);
    chk("stray_empty", {31'd0, o_empty}, 32'd1);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
